// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the fetch PC, selects the next PC and drives the imem req/ack handshake.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets trap to EXC_VECTOR and pulse misalign.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] fetch_count
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            advance;
    logic            redirect_pending;
    logic [AW-1:0]   redirect_addr;
    logic            redir_now;
    logic            use_redir;
    logic [AW-1:0]   jump_tgt;
    logic [AW-1:0]   redir_tgt;
    logic [AW-1:0]   sel_tgt;
    logic [AW-1:0]   next_pc;
`ifdef MISALIGN_TRAP_EN
    logic            trap;
`endif

    assign pc_plus4 = AW'(pc + 32'd4);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nxt;
    end

    // Next state and handshake; the request drops in the very cycle stall rises
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        advance   = 1'b0;
        case (state)
            BOOT:  state_nxt = stall ? HOLD : FETCH;
            FETCH: begin
                imem_req  = ~stall;
                advance   = imem_ack & ~stall;
                state_nxt = stall ? HOLD : FETCH;
            end
            HOLD:  state_nxt = stall ? HOLD : FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // Redirect selection: a redirect arriving this cycle beats a pending one, jump beats branch
    always_comb begin
        jump_tgt  = {pc_plus4[31:28], jump_index, 2'b00};
        redir_now = jump | branch_taken;
        redir_tgt = jump ? jump_tgt : branch_target;
        use_redir = redir_now | redirect_pending;
        sel_tgt   = redir_now ? redir_tgt : redirect_addr;
`ifdef MISALIGN_TRAP_EN
        trap      = use_redir & (sel_tgt[1:0] != 2'b00);
        next_pc   = trap ? EXC_VECTOR : (use_redir ? sel_tgt : pc_plus4);
`else
        next_pc   = use_redir ? (sel_tgt & ALIGN_MASK) : pc_plus4;
`endif
    end

    // PC, fetch bookkeeping and the held redirect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc               <= RESET_VECTOR;
            fetch_valid      <= 1'b0;
            fetch_count      <= '0;
            redirect_pending <= 1'b0;
            redirect_addr    <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign         <= 1'b0;
`endif
        end else begin
            fetch_valid <= advance;
`ifdef MISALIGN_TRAP_EN
            misalign    <= advance & trap;
`endif
            if (advance) begin
                pc               <= next_pc;
                fetch_count      <= AW'(fetch_count + 32'd1);
                redirect_pending <= 1'b0;
            end else if (redir_now) begin
                redirect_pending <= 1'b1;
                redirect_addr    <= redir_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, reset-mid-fetch sequence, randomized run vs reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] EXC = 32'h0000_0080;
`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC = EXC;
    localparam logic [31:0] MIS_P4 = EXC + 32'd4;
`else
    localparam logic [31:0] MIS_PC = 32'h0000_0100;
    localparam logic [31:0] MIS_P4 = 32'h0000_0104;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] fetch_count;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clock = ~clock;

    pc_fetch_unit dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_index(jump_index),
        .imem_ack(imem_ack),
        .imem_req(imem_req),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid),
        .fetch_count(fetch_count)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign(misalign)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic b, input logic [31:0] bt,
                         input logic j, input logic [25:0] ji);
        stall = s; imem_ack = a; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    endtask

    typedef struct {
        logic        s;
        logic        a;
        logic        b;
        logic [31:0] bt;
        logic        j;
        logic [25:0] ji;
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[24];

    // Reference model state: phase 0 boot, 1 fetching, 2 holding; pending redirect as a queue
    logic [31:0] m_pc;
    int          m_phase;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [31:0] m_pend[$];

    function automatic logic m_req(input logic s);
        return (m_phase == 1) && !s;
    endfunction

    task automatic model_step(input logic s, input logic a, input logic b, input logic [31:0] bt,
                              input logic j, input logic [25:0] ji);
        logic [31:0] p4, tgt, npc;
        bit          fire, is_redir;
        p4   = m_pc + 32'd4;
        tgt  = j ? {p4[31:28], ji, 2'b00} : bt;
        fire = m_req(s) && a;
        m_mis = 1'b0;
        if (fire) begin
            is_redir = 1'b1;
            if (j || b) npc = tgt;
            else if (m_pend.size() != 0) npc = m_pend[0];
            else begin npc = p4; is_redir = 1'b0; end
            if (is_redir && npc[1:0] != 2'b00) begin
`ifdef MISALIGN_TRAP_EN
                npc = EXC;
                m_mis = 1'b1;
`else
                npc[1:0] = 2'b00;
`endif
            end
            m_pend.delete();
            m_pc = npc;
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid = 1'b0;
            if (j || b) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
        end
        m_phase = s ? 2 : 1;
    endtask

    initial begin
        //              s  a  b  bt            j  ji        req pc            v  cnt
        tbl[0]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h0000_0000,1'b0,32'd0};
        tbl[1]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0004,1'b1,32'd1};
        tbl[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0008,1'b1,32'd2};
        tbl[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_000C,1'b1,32'd3};
        tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h0000_000C,1'b0,32'd3};
        tbl[5]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h0000_000C,1'b0,32'd3};
        tbl[6]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h0000_000C,1'b0,32'd3};
        tbl[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h0000_000C,1'b0,32'd3};
        tbl[8]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0010,1'b1,32'd4};
        tbl[9]  = '{1'b0,1'b0,1'b1,32'h100,      1'b0,26'h0,   1'b1,32'h0000_0010,1'b0,32'd4};
        tbl[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0010,1'b0,32'd4};
        tbl[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0100,1'b1,32'd5};
        tbl[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0104,1'b1,32'd6};
        tbl[13] = '{1'b0,1'b1,1'b1,32'h3000_0010,1'b0,26'h0,   1'b1,32'h3000_0010,1'b1,32'd7};
        tbl[14] = '{1'b0,1'b1,1'b1,32'h200,      1'b1,26'h40,  1'b1,32'h3000_0100,1'b1,32'd8};
        tbl[15] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,26'h80,  1'b0,32'h3000_0100,1'b0,32'd8};
        tbl[16] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b0,32'h3000_0100,1'b0,32'd8};
        tbl[17] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h3000_0200,1'b1,32'd9};
        tbl[18] = '{1'b0,1'b1,1'b1,32'h102,      1'b0,26'h0,   1'b1,MIS_PC,       1'b1,32'd10};
        tbl[19] = '{1'b0,1'b0,1'b1,32'h500,      1'b0,26'h0,   1'b1,MIS_PC,       1'b0,32'd10};
        tbl[20] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,26'h300, 1'b1,MIS_PC,       1'b0,32'd10};
        tbl[21] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0C00,1'b1,32'd11};
        tbl[22] = '{1'b0,1'b1,1'b1,32'hFFFF_FFFC,1'b0,26'h0,   1'b1,32'hFFFF_FFFC,1'b1,32'd12};
        tbl[23] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,   1'b1,32'h0000_0000,1'b1,32'd13};

        // Reset values while reset is held
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(fetch_valid), 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].ji);
            #1;
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
            check($sformatf("vec%0d_pc4", i), pc_plus4, tbl[i].pc + 32'd4);
            check($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_count", i), fetch_count, tbl[i].cnt);
`ifdef MISALIGN_TRAP_EN
            check($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(i == 18));
`endif
        end
        check("misalign_pc4_row18", MIS_P4, tbl[18].pc + 32'd4);

        // Reset mid-fetch: pending redirect is lost, ack right after release is ignored
        drive(1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 26'h0);
        @(posedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_count", fetch_count, 32'h0);
        check("midrst_req", 32'(imem_req), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        #1;
        check("boot_req", 32'(imem_req), 32'h0);
        @(posedge clock);
        #1;
        check("boot_ack_ignored_pc", pc, 32'h0);
        check("boot_ack_ignored_valid", 32'(fetch_valid), 32'h0);
        #1;
        check("post_boot_req", 32'(imem_req), 32'h1);
        @(posedge clock);
        #1;
        check("post_boot_pc", pc, 32'h4);
        check("post_boot_count", fetch_count, 32'h1);

        // Randomized run against the reference model
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_pc = 32'h0; m_phase = 0; m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        m_pend.delete();
        for (int n = 0; n < 3000; n++) begin
            logic        s, a, b, j;
            logic [31:0] bt;
            logic [25:0] ji;
            s  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 9) < 6);
            b  = ($urandom_range(0, 6) == 0);
            j  = ($urandom_range(0, 9) == 0);
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) bt = 32'hFFFF_FFF8 | (bt & 32'h4);
            ji = 26'($urandom);
            drive(s, a, b, bt, j, ji);
            #1;
            check("rnd_req", 32'(imem_req), 32'(m_req(s)));
            check("rnd_pc4", pc_plus4, m_pc + 32'd4);
            @(posedge clock);
            model_step(s, a, b, bt, j, ji);
            #1;
            check("rnd_pc", pc, m_pc);
            check("rnd_valid", 32'(fetch_valid), 32'(m_valid));
            check("rnd_count", fetch_count, m_cnt);
`ifdef MISALIGN_TRAP_EN
            check("rnd_misalign", 32'(misalign), 32'(m_mis));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the branch-target adder.
- Holds the architectural PC and produces pc_plus4, which is the adder's pc operand.
- Consumes the adder's 32-bit branch-target result and the jump index, selects the next PC, and drives a req/ack handshake to instruction memory.
- Branch and jump redirects are held pending until the current fetch completes, which preserves MIPS delay-slot ordering.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, trap target; used only with MISALIGN_TRAP_EN.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  downstream hazard; freezes PC and drops imem_req.
- branch_taken  in  1  one-cycle pulse; redirect to branch_target.
- branch_target  in  32  branch-target adder sum (shifted offset + pc_plus4).
- jump  in  1  one-cycle pulse; redirect to the jump target.
- jump_index  in  26  instr[25:0]; target = {pc_plus4[31:28], jump_index, 2'b00}.
- imem_ack  in  1  instruction memory has returned the word at pc.
- imem_req  out  1  fetch request for address pc.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational from the pc register, modulo 2^32.
- fetch_valid  out  1  registered one-cycle pulse: the word at the old pc was accepted.
- fetch_count  out  32  number of accepted fetches, wraps at 2^32.

Behaviour:
- Reset (async) values:
  - pc = RESET_VECTOR.
  - state = BOOT.
  - imem_req = 0, fetch_valid = 0, fetch_count = 0.
  - redirect_pending = 0, redirect_addr = 0.
- States:
  - BOOT: exactly one cycle after reset deasserts; go to FETCH if stall=0, else HOLD. imem_req = 0.
  - FETCH: imem_req = 1; pc stable until advance.
  - HOLD: imem_req = 0. Return to FETCH the cycle after stall falls. imem_ack in HOLD is ignored.
  - In FETCH, stall=1 forces HOLD on the next edge. imem_req is gated combinationally with ~stall, so it is 0 in the stall cycle.
- advance = (state==FETCH) & imem_ack & ~stall.
  - On advance: pc <= next_pc, fetch_valid <= 1, fetch_count <= fetch_count + 1.
  - Otherwise fetch_valid <= 0.
- next_pc priority:
  1. jump this cycle.
  2. branch_taken this cycle.
  3. redirect_pending (use redirect_addr).
  4. pc_plus4.
- Redirect not coincident with advance (any state, including BOOT and HOLD):
  - Latch redirect_pending <= 1 and redirect_addr <= target.
  - A newer redirect overwrites an older pending one.
  - jump beats branch_taken in the same cycle.
- A pending redirect clears on the advance that consumes it.
- No squash: the instruction at the current pc (delay slot) still completes with fetch_valid.
- Wrap: pc 32'hFFFF_FFFC + 4 gives 32'h0000_0000; no flag.
- Reset mid-fetch:
  - State returns to BOOT and the pending redirect is lost.
  - An imem_ack arriving the cycle after reset deasserts is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Selected redirect target with addr[1:0] != 0 causes pc <= EXC_VECTOR on that advance.
  - Adds output misalign (1 bit, reset 0), which pulses 1 for one cycle with the advance.
  - The pending redirect is cleared.
- MISALIGN_TRAP_EN undefined:
  - Targets are used with bits [1:0] forced to 2'b00.
  - No misalign port.

Test Plan:
- Reset release, stall=0, imem_ack held 1:
  - BOOT for 1 cycle, then pc sequence 0, 4, 8, C on successive edges.
  - fetch_valid high each cycle after the first FETCH; fetch_count=3 after 3 advances.
- pc=0x40, branch_taken with branch_target=0x100 while imem_ack=0:
  - pc stays 0x40.
  - On ack, pc=0x100 (no 0x44); fetch_valid pulses once.
- jump and branch_taken in the same advance cycle at pc=0x3000_0010, jump_index=0x000_0040, branch_target=0x200:
  - pc=0x3000_0100.
- stall raised in FETCH for 3 cycles with imem_ack=1 throughout:
  - imem_req=0, pc frozen, fetch_count unchanged.
  - Resumes FETCH one cycle after stall falls.
- pc=0xFFFF_FFFC, ack:
  - pc=0x0000_0000, pc_plus4=0x0000_0004.
- MISALIGN_TRAP_EN build, branch_target=0x102, ack:
  - pc=0x80 and misalign pulses once.
- Same stimulus without the macro:
  - pc=0x100.
